gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Self-checking stimulus/response engine for the two-input gate library (AND, OR, NAND, NOR, NOT, XOR, XNOR). On a start request it drives every input combination onto the shared `a`/`b` nets and samples the seven gate outputs after a programmable settle time. It compares them against internally computed expected values and reports a pass/fail summary with first-failure capture. It sits on the opposite side of the gate library from its consumers: it produces the inputs and consumes the outputs, for board bring-up and regression.

## Interface
- `SETTLE_CYCLES`, default 1: wait cycles between driving a vector and sampling `obs`; legal range 0..15.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..8.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — run request, sampled only in IDLE.
- `a`  out  1  — gate input A.
- `b`  out  1  — gate input B.
- `obs`  in  7  — gate outputs: bit0 AND, bit1 OR, bit2 NAND, bit3 NOR, bit4 NOT(a), bit5 XOR, bit6 XNOR.
- `busy`  out  1  — high whenever the state is not IDLE.
- `done`  out  1  — one-cycle pulse when a run completes.
- `pass`  out  1  — result of the last run; held until the next accepted start.
- `err_count`  out  4  — number of failing vectors; saturates at 15.
- `first_err_vec`  out  2  — {a,b} of the first failing vector.
- `first_err_mask`  out  7  — XOR of `obs` and expected at the first failure.

## Operation
- **States:** IDLE, DRIVE, WAIT, CHECK, DONE.
- **IDLE:**
  - `a` = `b` = 0.
  - `start` = 1 → DRIVE.
  - On acceptance, clear `vec`, the pass index, `err_count`, `pass`, `first_err_vec` and `first_err_mask`.
- **DRIVE:** `{a,b}` = `vec`. Next state is WAIT, or CHECK if `SETTLE_CYCLES` = 0.
- **WAIT:** stay for exactly `SETTLE_CYCLES` cycles with `a`/`b` held, then → CHECK.
- **CHECK:**
  - Compute `exp` from the current `a`/`b` and form `mask = obs ^ exp`.
  - If `mask` ≠ 0:
    - `err_count` increments, saturating at 15.
    - If this is the first failure of the run, capture `vec` into `first_err_vec` and `mask` into `first_err_mask`.
  - Vector order is `vec` = 00, 01, 10, 11, where `vec[1]` = a.
  - After `vec` = 11, the pass index increments.
  - If the last vector of the last pass was just checked → DONE; otherwise advance `vec` (wrapping 11 → 00) and go to DRIVE.
- **DONE:**
  - `done` = 1 for this cycle only.
  - `pass` is registered as (`err_count` == 0), including the final CHECK's update.
  - Next state is always IDLE.
- **Start handling:** `start` is ignored in every state except IDLE, including the DONE cycle. There is no queuing.
- **Output hold:** `a`/`b` hold the last vector through DONE and return to 0 in IDLE.
- **Result registers:** `pass`, `err_count` and the first-error registers hold after DONE until the next accepted start.
- **Reset:** `rst` overrides everything, including mid-run. On the next edge the state is IDLE and all outputs are 0. The aborted run produces no `done` pulse.

## Timing
- All outputs are registered.
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_vec`=0, `first_err_mask`=0.
- With `start` sampled high at edge 0, the FSM is in DRIVE during cycle 1.
- Each vector takes `SETTLE_CYCLES` + 2 cycles.
- `done` is high during cycle 4·`PASSES`·(`SETTLE_CYCLES`+2) + 1.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `obs` is sampled on the clock edge that ends the CHECK cycle, at least `SETTLE_CYCLES`+1 edges after `a`/`b` change.
- Default parameters: CHECK in cycles 3, 6, 9 and 12; `done` in cycle 13; IDLE in cycle 14.
- `SETTLE_CYCLES` = 0: CHECK in cycles 2, 4, 6 and 8; `done` in cycle 9.

## Test plan
- **Ideal gate model, default parameters, pulse start:**
  - `a`/`b` sequence 00, 01, 10, 11 (3 cycles each).
  - `done` in cycle 13, `pass`=1, `err_count`=0, `first_err_mask`=0.
- **NAND output stuck at 1:**
  - Only vector 11 fails.
  - `err_count`=1, `pass`=0, `first_err_vec`=2'b11, `first_err_mask`=7'b0000100.
- **`PASSES`=4, `obs` driven as the complement of the ideal model:**
  - 16 failures occur, so `err_count` saturates at 15 and `pass`=0.
  - `first_err_vec`=00, `first_err_mask`=7'h7F.
- **`start` held high continuously:**
  - A new run is accepted only in the IDLE cycles following each DONE; `done` recurs every 14 cycles.
  - A `start` pulse during cycles 1–13 has no effect.
- **`rst` asserted in cycle 7 of a run:**
  - From the next edge, all outputs are 0 and `busy`=0, with no `done` pulse.
  - A subsequent `start` runs a clean sweep with `pass`=1.
- **`SETTLE_CYCLES`=0 with the ideal model:** `done` in cycle 9, `pass`=1.

Source files
------------

// File: rtl/gate_exerciser_if.sv
// Signal bundle between the gate exerciser and the gate library / run controller.
// The master modport is the exerciser side; slave is the library plus run controller.
interface gate_exerciser_if;
  logic       start;
  logic       a;
  logic       b;
  logic [6:0] obs;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [1:0] first_err_vec;
  logic [6:0] first_err_mask;

  modport master (
    input  start, obs,
    output a, b, busy, done, pass, err_count, first_err_vec, first_err_mask
  );

  modport slave (
    output start, obs,
    input  a, b, busy, done, pass, err_count, first_err_vec, first_err_mask
  );
endinterface

// File: rtl/gate_exerciser.sv
// Sweeps all {a,b} combinations into the gate library and checks the seven outputs,
// reporting error count, pass flag and the first failing vector/mask.
module gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1
) (
  input logic             clk,
  input logic             rst,
  gate_exerciser_if.master bus
);

  typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} state_e;

  localparam logic [3:0] WaitLoad = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LastPass = 3'(PASSES - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] pidx_q, pidx_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [3:0] err_q, err_d;
  logic [1:0] fvec_q, fvec_d;
  logic [6:0] fmask_q, fmask_d;
  logic       pass_q, pass_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [6:0] expected;
  logic [6:0] mask;

  // Bit order matches obs: AND, OR, NAND, NOR, NOT(a), XOR, XNOR.
  assign expected = {~(a_q ^ b_q), a_q ^ b_q, ~a_q, ~(a_q | b_q), ~(a_q & b_q),
                     a_q | b_q, a_q & b_q};
  assign mask = bus.obs ^ expected;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pidx_d  = pidx_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fmask_d = fmask_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrive;
          vec_d   = 2'd0;
          pidx_d  = 3'd0;
          err_d   = 4'd0;
          pass_d  = 1'b0;
          fvec_d  = 2'd0;
          fmask_d = 7'd0;
        end
      end
      StDrive: begin
        wcnt_d  = WaitLoad;
        state_d = (SETTLE_CYCLES == 0) ? StCheck : StWait;
      end
      StWait: begin
        if (wcnt_q == 4'd0) state_d = StCheck;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      StCheck: begin
        if (mask != 7'd0) begin
          if (err_q != 4'd15) err_d = err_q + 4'd1;
          // A saturating counter never returns to zero, so zero means no earlier failure.
          if (err_q == 4'd0) begin
            fvec_d  = vec_q;
            fmask_d = mask;
          end
        end
        if (vec_q == 2'b11) pidx_d = pidx_q + 3'd1;
        if (vec_q == 2'b11 && pidx_q == LastPass) begin
          state_d = StDone;
          pass_d  = (err_d == 4'd0);
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = StDrive;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they are valid in the cycle they belong to.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    if (state_d == StIdle) begin
      a_d = 1'b0;
      b_d = 1'b0;
    end else if (state_d == StDrive) begin
      a_d = vec_d[1];
      b_d = vec_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= 2'd0;
      pidx_q  <= 3'd0;
      wcnt_q  <= 4'd0;
      err_q   <= 4'd0;
      fvec_q  <= 2'd0;
      fmask_q <= 7'd0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pidx_q  <= pidx_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_err_vec  = fvec_q;
  assign bus.first_err_mask = fmask_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: three parameterisations driven by a gate model
// with injectable faults; expected run results are queued at launch and checked on done.
module tb_gate_exerciser;

  typedef struct {
    logic        pass;
    logic [3:0]  err;
    logic [1:0]  fvec;
    logic [6:0]  fmask;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   fault0 = 0;
  int   fault1 = 2;
  int   fault2 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_exerciser_if bus0 ();
  gate_exerciser_if bus1 ();
  gate_exerciser_if bus2 ();

  gate_exerciser #(.SETTLE_CYCLES(1), .PASSES(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  gate_exerciser #(.SETTLE_CYCLES(1), .PASSES(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
  gate_exerciser #(.SETTLE_CYCLES(0), .PASSES(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  // Ideal gate library; fault 1 = NAND stuck at 1, fault 2 = every output inverted.
  function automatic logic [6:0] model(input logic a, input logic b, input int f);
    logic [6:0] e;
    e[0] = a & b;
    e[1] = a | b;
    e[2] = !(a && b);
    e[3] = !(a || b);
    e[4] = !a;
    e[5] = a != b;
    e[6] = a == b;
    if (f == 1) e[2] = 1'b1;
    if (f == 2) e = ~e;
    return e;
  endfunction

  assign bus0.obs = model(bus0.a, bus0.b, fault0);
  assign bus1.obs = model(bus1.a, bus1.b, fault1);
  assign bus2.obs = model(bus2.a, bus2.b, fault2);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    else passed++;
  endtask

  task automatic score(input string tag, input exp_t e, input logic p, input logic [3:0] ec,
                       input logic [1:0] fv, input logic [6:0] fm);
    chk({tag, " done time"}, cyc, e.at);
    chk({tag, " pass"}, 32'(p), 32'(e.pass));
    chk({tag, " err_count"}, 32'(ec), 32'(e.err));
    chk({tag, " first_err_vec"}, 32'(fv), 32'(e.fvec));
    chk({tag, " first_err_mask"}, 32'(fm), 32'(e.fmask));
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.done) begin
      if (q0.size() == 0) chk("dut0 spurious done", 32'(q0.size()), 1);
      else begin
        e = q0.pop_front();
        score("dut0", e, bus0.pass, bus0.err_count, bus0.first_err_vec, bus0.first_err_mask);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.done) begin
      if (q1.size() == 0) chk("dut1 spurious done", 32'(q1.size()), 1);
      else begin
        e = q1.pop_front();
        score("dut1", e, bus1.pass, bus1.err_count, bus1.first_err_vec, bus1.first_err_mask);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (bus2.done) begin
      if (q2.size() == 0) chk("dut2 spurious done", 32'(q2.size()), 1);
      else begin
        e = q2.pop_front();
        score("dut2", e, bus2.pass, bus2.err_count, bus2.first_err_vec, bus2.first_err_mask);
      end
    end
  end

  task automatic expect_run(input int inst, input logic p, input logic [3:0] ec,
                            input logic [1:0] fv, input logic [6:0] fm, input int unsigned t);
    exp_t e;
    e.pass  = p;
    e.err   = ec;
    e.fvec  = fv;
    e.fmask = fm;
    e.at    = cyc + t;
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called at a negedge; returns at the negedge inside cycle 1 of the run.
  task automatic launch(input int inst, input logic p, input logic [3:0] ec,
                        input logic [1:0] fv, input logic [6:0] fm, input int unsigned t);
    expect_run(inst, p, ec, fv, fm, t);
    case (inst)
      0:       bus0.start = 1'b1;
      1:       bus1.start = 1'b1;
      default: bus2.start = 1'b1;
    endcase
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
  endtask

  initial begin
    int base;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.err_count,
                          bus0.first_err_vec, bus0.first_err_mask}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ideal run: vectors 00,01,10,11 held three cycles each, last held through DONE.
    launch(0, 1'b1, 4'd0, 2'd0, 7'd0, 13);
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("ab cycle %0d", k), 32'({bus0.a, bus0.b}), (k == 13) ? 3 : (k - 1) / 3);
      chk($sformatf("busy cycle %0d", k), 32'(bus0.busy), 1);
      @(negedge clk);
    end
    chk("idle busy", 32'(bus0.busy), 0);
    chk("idle ab", 32'({bus0.a, bus0.b}), 0);
    repeat (3) @(negedge clk);
    chk("pass held", 32'(bus0.pass), 1);

    // A start pulse mid-run must neither restart nor queue a run.
    launch(0, 1'b1, 4'd0, 2'd0, 7'd0, 13);
    repeat (4) @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("no queued start", 32'(bus0.busy), 0);

    // NAND stuck at 1: only vector 11 fails.
    fault0 = 1;
    launch(0, 1'b0, 4'd1, 2'b11, 7'b0000100, 13);
    repeat (14) @(negedge clk);
    chk("fail result held", 32'(bus0.err_count), 1);
    fault0 = 0;

    // Start held high: back-to-back runs every 14 cycles.
    base = cyc;
    expect_run(0, 1'b1, 4'd0, 2'd0, 7'd0, 13);
    expect_run(0, 1'b1, 4'd0, 2'd0, 7'd0, 27);
    expect_run(0, 1'b1, 4'd0, 2'd0, 7'd0, 41);
    bus0.start = 1'b1;
    repeat (41) @(negedge clk);
    bus0.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held start stopped", 32'(bus0.busy), 0);
    chk("held start span", cyc - base, 44);

    // Reset in cycle 7 aborts without a done pulse.
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid-run a before reset", 32'(bus0.a), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort outputs", {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.err_count,
                          bus0.first_err_vec, bus0.first_err_mask}, 0);
    rst = 1'b0;
    @(negedge clk);
    launch(0, 1'b1, 4'd0, 2'd0, 7'd0, 13);
    repeat (14) @(negedge clk);

    // Four passes of complemented outputs: 16 failures saturate at 15.
    launch(1, 1'b0, 4'd15, 2'd0, 7'h7F, 49);
    repeat (50) @(negedge clk);

    // Zero settle time: two cycles per vector.
    launch(2, 1'b1, 4'd0, 2'd0, 7'd0, 9);
    repeat (10) @(negedge clk);

    chk("dut0 runs outstanding", 32'(q0.size()), 0);
    chk("dut1 runs outstanding", 32'(q1.size()), 0);
    chk("dut2 runs outstanding", 32'(q2.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
